// File: rtl/rename_reg_file_if.sv
// Dispatcher/ROB-facing bundle of the rename register file: issue, commit and two read ports.
interface rename_reg_file_if #(
   parameter int unsigned IDX_W    = 5,
   parameter int unsigned ROB_ID_W = 4,
   parameter int unsigned XLEN     = 32
);
   logic                rdy;
   logic                clear;
   logic                issue_en;
   logic [IDX_W-1:0]    issue_rd;
   logic [ROB_ID_W-1:0] issue_rob_id;
   logic                commit_en;
   logic [IDX_W-1:0]    commit_reg_id;
   logic [ROB_ID_W-1:0] commit_rob_tag;
   logic [XLEN-1:0]     commit_val;
   logic [IDX_W-1:0]    rs1_id;
   logic                rs1_busy;
   logic [ROB_ID_W-1:0] rs1_tag;
   logic [XLEN-1:0]     rs1_val;
   logic [IDX_W-1:0]    rs2_id;
   logic                rs2_busy;
   logic [ROB_ID_W-1:0] rs2_tag;
   logic [XLEN-1:0]     rs2_val;

   modport master (
      output rdy, clear, issue_en, issue_rd, issue_rob_id,
             commit_en, commit_reg_id, commit_rob_tag, commit_val, rs1_id, rs2_id,
      input  rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val
   );

   modport slave (
      input  rdy, clear, issue_en, issue_rd, issue_rob_id,
             commit_en, commit_reg_id, commit_rob_tag, commit_val, rs1_id, rs2_id,
      output rs1_busy, rs1_tag, rs1_val, rs2_busy, rs2_tag, rs2_val
   );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register ROB rename tags.
// Define RF_COMMIT_BYPASS_EN to forward an in-flight releasing commit to the read ports.
module rename_reg_file #(
   parameter int unsigned REG_NUM  = 32,
   parameter int unsigned ROB_ID_W = 4,
   parameter int unsigned XLEN     = 32
) (
   input logic               clk,
   input logic               rst_n,
   rename_reg_file_if.slave  rf
);
   localparam int unsigned IDX_W = $clog2(REG_NUM);

   logic [XLEN-1:0]     val_q  [REG_NUM];
   logic [ROB_ID_W-1:0] tag_q  [REG_NUM];
   logic [REG_NUM-1:0]  busy_q;

   logic commit_wr;
   logic commit_release;
   logic issue_wr;

   assign commit_wr      = rf.rdy && rf.commit_en && (rf.commit_reg_id != '0);
   assign commit_release = busy_q[rf.commit_reg_id] && (tag_q[rf.commit_reg_id] == rf.commit_rob_tag);
   assign issue_wr       = rf.rdy && rf.issue_en && !rf.clear && (rf.issue_rd != '0);

   // Later assignments take priority: clear over commit release, issue over commit release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < REG_NUM; i++) begin
            val_q[i] <= '0;
            tag_q[i] <= '0;
         end
         busy_q <= '0;
      end else if (rf.rdy) begin
         if (commit_wr) begin
            val_q[rf.commit_reg_id] <= rf.commit_val;
            if (commit_release)
               busy_q[rf.commit_reg_id] <= 1'b0;
         end
         if (rf.clear) begin
            busy_q <= '0;
         end else if (issue_wr) begin
            busy_q[rf.issue_rd] <= 1'b1;
            tag_q[rf.issue_rd]  <= rf.issue_rob_id;
         end
      end
   end

`ifdef RF_COMMIT_BYPASS_EN
   logic bypass1;
   logic bypass2;
   assign bypass1 = commit_wr && commit_release && (rf.commit_reg_id == rf.rs1_id);
   assign bypass2 = commit_wr && commit_release && (rf.commit_reg_id == rf.rs2_id);
`endif

   always_comb begin
      rf.rs1_busy = 1'b0;
      rf.rs1_tag  = '0;
      rf.rs1_val  = '0;
      if (rf.rs1_id != '0) begin
         rf.rs1_busy = busy_q[rf.rs1_id];
         rf.rs1_tag  = tag_q[rf.rs1_id];
         rf.rs1_val  = val_q[rf.rs1_id];
      end
`ifdef RF_COMMIT_BYPASS_EN
      if (bypass1) begin
         rf.rs1_busy = 1'b0;
         rf.rs1_val  = rf.commit_val;
      end
`endif
   end

   always_comb begin
      rf.rs2_busy = 1'b0;
      rf.rs2_tag  = '0;
      rf.rs2_val  = '0;
      if (rf.rs2_id != '0) begin
         rf.rs2_busy = busy_q[rf.rs2_id];
         rf.rs2_tag  = tag_q[rf.rs2_id];
         rf.rs2_val  = val_q[rf.rs2_id];
      end
`ifdef RF_COMMIT_BYPASS_EN
      if (bypass2) begin
         rf.rs2_busy = 1'b0;
         rf.rs2_val  = rf.commit_val;
      end
`endif
   end

   initial assert (IDX_W == 5) else $error("rename_reg_file: index width must be 5");
endmodule

// File: tb/tb_rename_reg_file.sv
// Directed table-driven bench for rename_reg_file; reads are checked before each row's clock edge.
module tb_rename_reg_file;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   rename_reg_file_if #(.IDX_W(5), .ROB_ID_W(4), .XLEN(32)) rf ();

   rename_reg_file #(.REG_NUM(32), .ROB_ID_W(4), .XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (rf.slave)
   );

   typedef struct {
      int          rdy, clr, ie, ird, itag, ce, creg, ctag;
      logic [31:0] cval;
      int          r1, r2;
      int          b1, t1;
      logic [31:0] v1;
      int          b2, t2;
      logic [31:0] v2;
   } vec_t;

   vec_t vt [20];

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rf.rdy            = 1'(v.rdy);
      rf.clear          = 1'(v.clr);
      rf.issue_en       = 1'(v.ie);
      rf.issue_rd       = 5'(v.ird);
      rf.issue_rob_id   = 4'(v.itag);
      rf.commit_en      = 1'(v.ce);
      rf.commit_reg_id  = 5'(v.creg);
      rf.commit_rob_tag = 4'(v.ctag);
      rf.commit_val     = v.cval;
      rf.rs1_id         = 5'(v.r1);
      rf.rs2_id         = 5'(v.r2);
   endtask

   task automatic idle();
      rf.rdy = 1'b1; rf.clear = 1'b0; rf.issue_en = 1'b0; rf.commit_en = 1'b0;
      rf.issue_rd = '0; rf.issue_rob_id = '0; rf.commit_reg_id = '0;
      rf.commit_rob_tag = '0; rf.commit_val = '0;
   endtask

   initial begin
      //          rdy clr ie ird itag ce creg ctag cval          r1 r2 b1 t1 v1             b2 t2 v2
      vt[0]  = '{1, 0, 1, 5, 3,  0, 0, 0,  32'h0,        5, 0, 0, 0, 32'h0,        0, 0, 32'h0};
      vt[1]  = '{1, 0, 0, 0, 0,  0, 0, 0,  32'h0,        5, 7, 1, 3, 32'h0,        0, 0, 32'h0};
      vt[2]  = '{1, 0, 0, 0, 0,  1, 5, 3,  32'hDEADBEEF, 7, 0, 0, 0, 32'h0,        0, 0, 32'h0};
      vt[3]  = '{1, 0, 0, 0, 0,  0, 0, 0,  32'h0,        5, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0};
      vt[4]  = '{1, 0, 1, 7, 2,  0, 0, 0,  32'h0,        5, 7, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0};
      vt[5]  = '{1, 0, 1, 7, 4,  0, 0, 0,  32'h0,        0, 7, 0, 0, 32'h0,        1, 2, 32'h0};
      vt[6]  = '{1, 0, 0, 0, 0,  1, 7, 2,  32'h11,       7, 0, 1, 4, 32'h0,        0, 0, 32'h0};
      vt[7]  = '{1, 0, 0, 0, 0,  0, 0, 0,  32'h0,        7, 0, 1, 4, 32'h11,       0, 0, 32'h0};
      vt[8]  = '{1, 0, 0, 0, 0,  1, 7, 4,  32'h22,       5, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0};
      vt[9]  = '{1, 0, 1, 9, 1,  0, 0, 0,  32'h0,        7, 0, 0, 0, 32'h22,       0, 0, 32'h0};
      vt[10] = '{1, 0, 1, 9, 6,  1, 9, 1,  32'h55,       7, 0, 0, 0, 32'h22,       0, 0, 32'h0};
      vt[11] = '{1, 0, 1, 3, 8,  0, 0, 0,  32'h0,        9, 0, 1, 6, 32'h55,       0, 0, 32'h0};
      vt[12] = '{1, 0, 1, 4, 9,  0, 0, 0,  32'h0,        3, 0, 1, 8, 32'h0,        0, 0, 32'h0};
      vt[13] = '{1, 1, 1, 8, 10, 1, 3, 5,  32'h77,       4, 3, 1, 9, 32'h0,        1, 8, 32'h0};
      vt[14] = '{1, 0, 0, 0, 0,  0, 0, 0,  32'h0,        3, 4, 0, 0, 32'h77,       0, 0, 32'h0};
      vt[15] = '{1, 0, 0, 0, 0,  0, 0, 0,  32'h0,        8, 9, 0, 0, 32'h0,        0, 0, 32'h55};
      vt[16] = '{1, 0, 1, 0, 5,  1, 0, 0,  32'hFF,       9, 0, 0, 0, 32'h55,       0, 0, 32'h0};
      vt[17] = '{1, 0, 0, 0, 0,  0, 0, 0,  32'h0,        0, 0, 0, 0, 32'h0,        0, 0, 32'h0};
      vt[18] = '{0, 0, 1, 12, 7, 1, 9, 0,  32'h1234,     12, 0, 0, 0, 32'h0,       0, 0, 32'h0};
      vt[19] = '{1, 0, 0, 0, 0,  0, 0, 0,  32'h0,        12, 9, 0, 0, 32'h0,       0, 0, 32'h55};

      idle();
      rf.rs1_id = 5'd5; rf.rs2_id = 5'd31;
      repeat (2) @(negedge clk);
      chk("reset_busy1", -1, 32'(rf.rs1_busy), 32'h0);
      chk("reset_val1", -1, rf.rs1_val, 32'h0);
      chk("reset_busy2", -1, 32'(rf.rs2_busy), 32'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         chk("rs1_busy", i, 32'(rf.rs1_busy), 32'(vt[i].b1));
         chk("rs1_val", i, rf.rs1_val, vt[i].v1);
         if (vt[i].b1 != 0) chk("rs1_tag", i, 32'(rf.rs1_tag), 32'(vt[i].t1));
         chk("rs2_busy", i, 32'(rf.rs2_busy), 32'(vt[i].b2));
         chk("rs2_val", i, rf.rs2_val, vt[i].v2);
         if (vt[i].b2 != 0) chk("rs2_tag", i, 32'(rf.rs2_tag), 32'(vt[i].t2));
      end

      // Commit to a busy register with matching tag while reading it in the same cycle.
      @(negedge clk);
      idle();
      rf.issue_en = 1'b1; rf.issue_rd = 5'd20; rf.issue_rob_id = 4'd11;
      @(negedge clk);
      idle();
      rf.commit_en = 1'b1; rf.commit_reg_id = 5'd20; rf.commit_rob_tag = 4'd11;
      rf.commit_val = 32'hCAFEF00D; rf.rs1_id = 5'd20; rf.rs2_id = 5'd20;
      #1;
`ifdef RF_COMMIT_BYPASS_EN
      chk("bypass_busy", 100, 32'(rf.rs1_busy), 32'h0);
      chk("bypass_val", 100, rf.rs1_val, 32'hCAFEF00D);
`else
      chk("inflight_busy", 100, 32'(rf.rs1_busy), 32'h1);
      chk("inflight_tag", 100, 32'(rf.rs1_tag), 32'd11);
      chk("inflight_val", 100, rf.rs1_val, 32'h0);
`endif
      @(negedge clk);
      idle();
      #1;
      chk("post_commit_busy", 101, 32'(rf.rs2_busy), 32'h0);
      chk("post_commit_val", 101, rf.rs2_val, 32'hCAFEF00D);

      // Asynchronous reset mid-cycle, no clock edge in between.
      rf.rs1_id = 5'd7; rf.rs2_id = 5'd9;
      #1;
      chk("pre_reset_val", 102, rf.rs1_val, 32'h22);
      rst_n = 1'b0;
      #1;
      chk("async_reset_val1", 102, rf.rs1_val, 32'h0);
      chk("async_reset_val2", 102, rf.rs2_val, 32'h0);
      chk("async_reset_busy2", 102, 32'(rf.rs2_busy), 32'h0);
      #1;
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Architectural register file with per-register rename tags; the consumer end of the ROB commit interface.
- The dispatcher reads operands through it: each read returns either a committed value, or the ROB tag that will produce the value.
- On issue, the dispatcher marks the destination register as renamed to the new ROB entry.
- On commit, the ROB writes the retired value back and releases the rename when the tags match.
- On clear (mispredict), all renames are flushed.

Parameters:
- REG_NUM, 32: number of architectural registers (index width = 5).
- ROB_ID_W, 4: ROB tag width (16-entry ROB).
- XLEN, 32: data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; state holds when low.
- clear  in  1  ROB flush; drops all renames.
- issue_en  in  1  dispatcher issues an instruction this cycle.
- issue_rd  in  5  destination register of the issued instruction.
- issue_rob_id  in  ROB_ID_W  ROB entry allocated to it (the ROB's free_rob_id).
- commit_en  in  1  ROB retires an entry this cycle.
- commit_reg_id  in  5  destination register of the retired entry.
- commit_rob_tag  in  ROB_ID_W  ROB entry being retired.
- commit_val  in  XLEN  retired result.
- rs1_id  in  5  operand-1 register index.
- rs1_busy  out  1  operand 1 is pending.
- rs1_tag  out  ROB_ID_W  ROB tag producing operand 1 (valid when rs1_busy).
- rs1_val  out  XLEN  operand-1 value (valid when !rs1_busy).
- rs2_id  in  5  operand-2 register index.
- rs2_busy  out  1  operand 2 is pending.
- rs2_tag  out  ROB_ID_W  ROB tag producing operand 2 (valid when rs2_busy).
- rs2_val  out  XLEN  operand-2 value (valid when !rs2_busy).

Behaviour:
- State per register: val[XLEN], busy[1], tag[ROB_ID_W].
- Reset (async, rst_n low): all val = 0, busy = 0, tag = 0.
  - Consequently rs*_busy = 0, rs*_tag = 0, rs*_val = 0 for every index.
- rdy low: no state change. Read ports remain combinational on the current state.
- Read ports are combinational with zero latency:
  - busy = busy[id]; tag = tag[id]; val = val[id].
  - id == 0 always returns busy = 0, tag = 0, val = 0.
- Commit write (rdy and commit_en and commit_reg_id != 0):
  - val[reg] <= commit_val unconditionally (values retire in order).
  - busy[reg] <= 0 only if busy[reg] and tag[reg] == commit_rob_tag and the register is not overwritten by the same-cycle issue rule below.
  - On a tag mismatch (a newer producer exists), busy/tag are untouched.
- Issue rename (rdy and issue_en and !clear and issue_rd != 0):
  - busy[rd] <= 1, tag[rd] <= issue_rob_id.
- Same-cycle issue and commit to the same register:
  - The issue wins for busy/tag (busy = 1, tag = issue_rob_id).
  - The commit still writes val.
- Clear (rdy and clear):
  - All busy <= 0.
  - A commit in the same cycle still writes val.
  - Issue is ignored.
  - tag contents are don't-care after clear.
- Writes to x0 from commit or issue are dropped; x0 is never busy.
- Reads in the same cycle as a write return the pre-edge state, unless the optional bypass is enabled.
- Tag wrap-around: tags are compared as raw ROB_ID_W-bit values. The ROB guarantees no two live entries share a tag.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- Defined: each read port compares against the commit in flight.
  - Match condition: commit_en and rdy and commit_reg_id == id != 0 and busy[id] and tag[id] == commit_rob_tag.
  - On a match: busy = 0, val = commit_val.
  - This saves the dispatcher one cycle of waiting on the RS/LSB broadcast.
- Undefined: read ports reflect registered state only; the dispatcher relies on the commit broadcast.

Test Plan:
- Reset: pulse rst_n low mid-cycle with no clock edge -> all rs*_busy = 0 and rs*_val = 0 immediately.
- Issue rd = 5, tag = 3; next cycle read rs1_id = 5 -> rs1_busy = 1, rs1_tag = 3. Then commit reg 5, tag 3, val 0xDEADBEEF -> next cycle busy = 0, val = 0xDEADBEEF.
- Tag mismatch: issue x7 with tag 2, then x7 with tag 4; commit x7 tag 2 val 0x11 -> val = 0x11, busy = 1, tag = 4. Commit tag 4 val 0x22 -> busy = 0, val = 0x22.
- Same-cycle issue x9 tag 6 and commit x9 tag 1 val 0x55 (busy with tag 1) -> busy = 1, tag = 6, val = 0x55.
- Clear: x3 and x4 busy; assert clear with commit x3 val 0x77 and issue_en x8 -> all busy = 0, x3 val = 0x77, x8 not busy.
- x0: issue rd = 0 and commit reg 0 val 0xFF -> rs1_id = 0 reads busy = 0, val = 0. With RF_COMMIT_BYPASS_EN defined, a matching read in the commit cycle returns busy = 0, val = commit_val combinationally.
